rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of the register-file write port.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of architectural registers (scoreboard bits).
REQ-003 SHALL have parameter AW, default 5, meaning register address width.
REQ-004 SHALL have port clk  input  1  meaning single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-006 SHALL have ports req0_valid  input  1, req0_addr  input  AW, req0_data  input  WIDTH  meaning ALU writeback request.
REQ-007 SHALL have port req0_ready  output  1  meaning req0 accepted this cycle.
REQ-008 SHALL have ports req1_valid  input  1, req1_addr  input  AW, req1_data  input  WIDTH  meaning load-unit writeback request.
REQ-009 SHALL have port req1_ready  output  1  meaning req1 accepted this cycle.
REQ-010 SHALL have ports wr_en  output  1, wr_addr  output  AW, wr_data  output  WIDTH  meaning registered drive of the register-file write port.
REQ-011 SHALL have port grant_id  output  1  meaning requester that produced the current wr_en pulse (0=req0, 1=req1).
REQ-012 SHALL have ports issue_valid  input  1, issue_addr  input  AW  meaning decode marks a destination register pending.
REQ-013 SHALL have ports chk_addr_a, chk_addr_b  input  AW  and chk_busy_a, chk_busy_b  output  1  meaning scoreboard lookup for two source operands.

Function
REQ-014 SHALL accept at most one request per cycle; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-015 SHALL drive reqN_ready combinationally: only one valid -> that one ready; both valid -> grant the requester not granted in the most recent transfer; neither valid -> both ready low.
REQ-016 SHALL update the round-robin pointer last_grant only on a transfer; idle cycles leave it unchanged.
REQ-017 SHALL, for a transfer with address != 0, drive wr_en=1, wr_addr, wr_data, grant_id from the accepted request on the next cycle (latency exactly 1 cycle); otherwise wr_en=0 that cycle.
REQ-018 SHALL accept transfers to address 0 (ready asserted, pointer advances) but SHALL NOT assert wr_en for them.
REQ-019 SHALL hold wr_addr, wr_data, grant_id at their last values when wr_en=0.
REQ-020 SHALL sustain back-to-back transfers, one wr_en pulse per cycle, with no bubble.
REQ-021 SHALL hold a DEPTH-bit scoreboard; issue_valid with issue_addr != 0 sets bit issue_addr at the clock edge.
REQ-022 SHALL clear scoreboard bit wr_addr on every cycle in which wr_en=1.
REQ-023 SHALL, when a set and a clear target the same bit in the same cycle, leave the bit set (new issue wins).
REQ-024 SHALL keep scoreboard bit 0 permanently 0; issue to address 0 is ignored.
REQ-025 SHALL drive chk_busy_a/b combinationally from the registered scoreboard (no same-cycle bypass of issue or clear).
REQ-026 SHALL treat a request held valid without ready as stalled; data/address stability is the requester's obligation, and the arbiter SHALL NOT buffer it.

Reset
REQ-027 SHALL, while rst=1, force wr_en=0, wr_addr=0, wr_data=0, grant_id=0, scoreboard all 0, last_grant=1 (req0 wins first contention), and req0_ready=req1_ready=0.
REQ-028 SHALL, on rst asserted mid-transfer, drop any pending wr_en pulse; the first post-reset cycle SHALL behave as a fresh arbitration.

Verification
REQ-029 Single requester: req0_valid=1, addr=5, data=0xDEADBEEF for one cycle -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=0.
REQ-030 Contention: both valid continuously, req0 addr=1, req1 addr=2, after reset -> grants alternate req0, req1, req0, req1 with wr_en high every cycle.
REQ-031 x0 filter: req1_valid=1, addr=0, data=0x12345678 -> req1_ready=1; next cycle wr_en=0; pointer advances (next contention grants req0).
REQ-032 Scoreboard: issue addr=7 -> chk_busy_a(7)=1 next cycle; req0 writes addr 7 -> bit clears the cycle after wr_en pulse; issue addr=7 in same cycle as wr_en to 7 -> bit remains 1.
REQ-033 Async reset: assert rst between clock edges during contention with scoreboard bits 3,9 set -> outputs and scoreboard zero immediately, no wr_en after release, first contention grants req0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load unit,
// registered write port, and a pending-destination scoreboard.
module rf_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             grant_id,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  input  logic [AW-1:0]    chk_addr_a,
  input  logic [AW-1:0]    chk_addr_b,
  output logic             chk_busy_a,
  output logic             chk_busy_b
);

  logic             r_last_grant;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_grant_id;
  logic [DEPTH-1:0] r_sb;

  logic             w_pick0;
  logic             w_pick1;
  logic             w_xfer;
  logic             w_write;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic [DEPTH-1:0] w_sb_set;
  logic [DEPTH-1:0] w_sb_clr;
  logic [DEPTH-1:0] w_sb_nxt;
  logic [DEPTH-1:0] w_oh_a;
  logic [DEPTH-1:0] w_oh_b;

  // r_last_grant=1 means req1 won last, so req0 wins the next contention
  always_comb begin
    w_pick0 = !rst && req0_valid && (!req1_valid || r_last_grant);
    w_pick1 = !rst && req1_valid && (!req0_valid || !r_last_grant);
    w_xfer  = w_pick0 || w_pick1;
    w_addr  = w_pick1 ? req1_addr : req0_addr;
    w_data  = w_pick1 ? req1_data : req0_data;
    w_write = w_xfer && (w_addr != '0);
  end

  assign req0_ready = w_pick0;
  assign req1_ready = w_pick1;

  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    w_oh_a   = '0;
    w_oh_b   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sb_set[i] = issue_valid && (issue_addr == AW'(i));
      w_sb_clr[i] = r_wr_en && (r_wr_addr == AW'(i));
      w_oh_a[i]   = (chk_addr_a == AW'(i));
      w_oh_b[i]   = (chk_addr_b == AW'(i));
    end
    // set after clear: a new issue beats a same-cycle writeback
    w_sb_nxt    = (r_sb & ~w_sb_clr) | w_sb_set;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_grant_id   <= 1'b0;
      r_sb         <= '0;
    end else begin
      if (w_xfer) begin
        r_last_grant <= w_pick1;
      end
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr  <= w_addr;
        r_wr_data  <= w_data;
        r_grant_id <= w_pick1;
      end
      r_sb <= w_sb_nxt;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign grant_id   = r_grant_id;
  assign chk_busy_a = |(r_sb & w_oh_a);
  assign chk_busy_b = |(r_sb & w_oh_b);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected writebacks are queued
// at acceptance and popped one cycle later; scoreboard bits are modelled.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        grant_id;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  chk_addr_a;
  logic [4:0]  chk_addr_b;
  logic        chk_busy_a;
  logic        chk_busy_b;

  rf_wb_arbiter #(.WIDTH(32), .DEPTH(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .grant_id(grant_id),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .chk_busy_a(chk_busy_a), .chk_busy_b(chk_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        id;
  } wb_t;

  wb_t         q[$];
  int          n_pass;
  int          n_total;
  logic        m_last;
  logic [31:0] m_sb;
  logic [31:0] m_sb_nxt;
  logic [4:0]  m_hold_a;
  logic [31:0] m_hold_d;
  logic        m_hold_id;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_last    = 1'b1;
    m_sb      = '0;
    m_sb_nxt  = '0;
    m_hold_a  = '0;
    m_hold_d  = '0;
    m_hold_id = 1'b0;
  endtask

  task automatic step(input logic v0, input logic [4:0] a0,
                      input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1,
                      input logic [31:0] d1,
                      input logic iv, input logic [4:0] ia,
                      input logic [4:0] ca, input logic [4:0] cb);
    wb_t         e;
    logic        have;
    logic        p0;
    logic        p1;
    logic [31:0] clr;
    logic [31:0] set;
    @(negedge clk);
    m_sb = m_sb_nxt;
    have = (q.size() > 0);
    clr  = '0;
    if (have) begin
      e = q.pop_front();
      chk("wr_en", 64'(wr_en), 64'(1));
      chk("wr_addr", 64'(wr_addr), 64'(e.a));
      chk("wr_data", 64'(wr_data), 64'(e.d));
      chk("grant_id", 64'(grant_id), 64'(e.id));
      m_hold_a  = e.a;
      m_hold_d  = e.d;
      m_hold_id = e.id;
      clr[e.a]  = 1'b1;
    end else begin
      chk("wr_en_idle", 64'(wr_en), 64'(0));
      chk("hold_addr", 64'(wr_addr), 64'(m_hold_a));
      chk("hold_data", 64'(wr_data), 64'(m_hold_d));
      chk("hold_id", 64'(grant_id), 64'(m_hold_id));
    end
    req0_valid  = v0;
    req0_addr   = a0;
    req0_data   = d0;
    req1_valid  = v1;
    req1_addr   = a1;
    req1_data   = d1;
    issue_valid = iv;
    issue_addr  = ia;
    chk_addr_a  = ca;
    chk_addr_b  = cb;
    #1;
    chk("busy_a", 64'(chk_busy_a), 64'(m_sb[ca]));
    chk("busy_b", 64'(chk_busy_b), 64'(m_sb[cb]));
    p0 = v0 && (!v1 || m_last);
    p1 = v1 && (!v0 || !m_last);
    chk("req0_ready", 64'(req0_ready), 64'(p0));
    chk("req1_ready", 64'(req1_ready), 64'(p1));
    if (p0 || p1) begin
      m_last = p1;
      if ((p1 ? a1 : a0) != 5'd0) begin
        e.a  = p1 ? a1 : a0;
        e.d  = p1 ? d1 : d0;
        e.id = p1;
        q.push_back(e);
      end
    end
    set = '0;
    if (iv) set[ia] = 1'b1;
    m_sb_nxt    = (m_sb & ~clr) | set;
    m_sb_nxt[0] = 1'b0;
  endtask

  task automatic idle(input logic [4:0] ca, input logic [4:0] cb);
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, cb);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_reset();
    rst         = 1'b1;
    req0_valid  = 1'b1;
    req0_addr   = 5'd4;
    req0_data   = 32'h1;
    req1_valid  = 1'b1;
    req1_addr   = 5'd6;
    req1_data   = 32'h2;
    issue_valid = 1'b0;
    issue_addr  = '0;
    chk_addr_a  = 5'd0;
    chk_addr_b  = 5'd1;
    #12;
    chk("rst_ready0", 64'(req0_ready), 64'(0));
    chk("rst_ready1", 64'(req1_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // contention straight after reset: req0, req1, req0, req1
    for (int i = 0; i < 4; i++)
      step(1, 1, 32'hA000 + i, 1, 2, 32'hB000 + i, 0, 0, 1, 2);
    idle(1, 2);

    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);

    // x0 write is accepted but filtered; next contention goes to req0
    step(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0);
    idle(0, 0);
    step(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 3, 4);
    step(1, 3, 32'h55, 1, 4, 32'h66, 0, 0, 3, 4);
    idle(3, 4);

    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    step(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(1, 7, 32'h78, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    idle(7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 7);
    idle(0, 7);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    idle(0, 0);
    idle(0, 0);

    step(0, 0, 0, 0, 0, 0, 1, 3, 3, 9);
    step(0, 0, 0, 0, 0, 0, 1, 9, 3, 9);
    idle(3, 9);
    step(1, 10, 32'hC0, 1, 11, 32'hC1, 0, 0, 3, 9);
    step(1, 10, 32'hC2, 1, 11, 32'hC3, 0, 0, 3, 9);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'(0));
    chk("arst_wr_addr", 64'(wr_addr), 64'(0));
    chk("arst_wr_data", 64'(wr_data), 64'(0));
    chk("arst_grant", 64'(grant_id), 64'(0));
    chk("arst_ready0", 64'(req0_ready), 64'(0));
    chk("arst_ready1", 64'(req1_ready), 64'(0));
    chk("arst_busy3", 64'(chk_busy_a), 64'(0));
    chk("arst_busy9", 64'(chk_busy_b), 64'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3, 9);
    step(1, 10, 32'hD0, 1, 11, 32'hD1, 0, 0, 3, 9);
    chk("post_rst_first_grant", 64'(req0_ready), 64'(1));
    step(1, 10, 32'hD2, 1, 11, 32'hD3, 0, 0, 3, 9);
    idle(3, 9);
    idle(3, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
